// File: rtl/sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_pkg
// Shared constants and sizing helpers for the synchronous FIFO family.
//   FWFT_OFF / FWFT_ON : read-mode selectors for the FWFT parameter
//   ptr_w(depth)       : bits needed to address 0..depth-1 (at least 1)
//   cnt_w(depth)       : bits needed to hold an occupancy of 0..depth
// ---------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  function automatic int ptr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// ---------------------------------------------------------------------------
// fifo_ram
// Simple dual-port storage for the FIFO: synchronous write, asynchronous read.
// Contents are not reset; the FIFO control logic decides what is valid.
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write address (0..DEPTH-1)
//   wdata : write data
//   raddr : read address (0..DEPTH-1)
//   rdata : read data, combinational from raddr
// ---------------------------------------------------------------------------
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// ---------------------------------------------------------------------------
// param_sync_fifo
// Single-clock FIFO with arbitrary (non power-of-two) depth, occupancy and
// threshold flags, sticky error flags, synchronous flush and a selectable
// registered-read or first-word-fall-through output.
// Ports:
//   clk          : clock, all state changes on the rising edge
//   rst          : asynchronous reset, active low
//   flush        : synchronous clear of queue contents and error flags
//   w_in/data_in : write request and data
//   r_in         : read request
//   data_out     : read data (registered in FWFT=0, head word in FWFT=1)
//   fifo_empty/fifo_full/almost_empty/almost_full : flags from count
//   count        : current occupancy 0..DEPTH
//   overflow/underflow : sticky flags for rejected writes / reads
// ---------------------------------------------------------------------------
module param_sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = FWFT_OFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   w_in,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   r_in,
  output logic [WIDTH-1:0]       data_out,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  output logic                   almost_empty,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if (DEPTH < 2 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_bad_params
    $error("param_sync_fifo: need DEPTH>=2 and AE_THRESH < AF_THRESH <= DEPTH");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rd_acc, wr_acc, ram_we;
  logic [WIDTH-1:0] ram_rdata;

  // Explicit wrap: DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A write into a full FIFO is still accepted when a read frees a slot
  // on the same edge.
  assign rd_acc = r_in & ~fifo_empty;
  assign wr_acc = w_in & (~fifo_full | rd_acc);
  assign ram_we = wr_acc & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    dout_d   = dout_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = next_ptr(wr_ptr_q);
      if (rd_acc) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
        dout_d   = ram_rdata;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (w_in && !wr_acc) ovf_d = 1'b1;
      if (r_in && !rd_acc) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      dout_q   <= dout_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  assign fifo_empty   = (count_q == '0);
  assign fifo_full    = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // FWFT shows the head word straight from the RAM; zero while empty.
  assign data_out = (FWFT == FWFT_ON) ? (fifo_empty ? '0 : ram_rdata) : dout_q;

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, entry count (>=2); non-power-of-two values are legal.
REQ-003 SHALL have parameter AF_THRESH, default DEPTH-2, almost_full assertion level.
REQ-004 SHALL have parameter AE_THRESH, default 2, almost_empty assertion level.
REQ-005 SHALL have parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 SHALL have port clk, input, 1, single clock; all state changes on the rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port flush, input, 1, synchronous clear of queue contents.
REQ-009 SHALL have port w_in, input, 1, write request.
REQ-010 SHALL have port data_in, input, WIDTH, write data.
REQ-011 SHALL have port r_in, input, 1, read request.
REQ-012 SHALL have port data_out, output, WIDTH, read data.
REQ-013 SHALL have ports fifo_empty and fifo_full, output, 1 each, occupancy flags.
REQ-014 SHALL have ports almost_empty and almost_full, output, 1 each, threshold flags.
REQ-015 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.
REQ-016 SHALL have ports overflow and underflow, output, 1 each, sticky error flags.

Function
REQ-017 SHALL accept a write when w_in=1 and (fifo_full=0 or an accepted read occurs in the same cycle).
REQ-018 SHALL accept a read when r_in=1 and fifo_empty=0.
REQ-019 SHALL allow a simultaneous accepted read and write; count unchanged, both pointers advance.
REQ-020 SHALL wrap each pointer from DEPTH-1 to 0 explicitly; no reliance on modulo-2^n overflow.
REQ-021 SHALL set count +1 on write-only, -1 on read-only, unchanged otherwise; count never leaves 0..DEPTH.
REQ-022 SHALL drive fifo_empty=(count==0), fifo_full=(count==DEPTH), almost_full=(count>=AF_THRESH), almost_empty=(count<=AE_THRESH), all combinational from registered count.
REQ-023 FWFT=0: SHALL register the head word onto data_out on the edge accepting the read (1-cycle latency) and hold data_out otherwise.
REQ-024 FWFT=1: SHALL present the head word on data_out whenever fifo_empty=0, with an accepted read advancing to the next word; a write to an empty FIFO SHALL appear one cycle after the write edge; data_out SHALL be 0 when empty.
REQ-025 SHALL set overflow when w_in=1 is rejected and underflow when r_in=1 is rejected; both stay set until reset or flush.
REQ-026 A rejected access SHALL change neither pointers, count nor memory.
REQ-027 flush=1 SHALL take priority over w_in/r_in: pointers, count, overflow and underflow go to 0 next edge; memory is not cleared; in FWFT=0, data_out holds.

Reset
REQ-028 rst=0 SHALL asynchronously force pointers=0, count=0, data_out=0, overflow=0, underflow=0, giving fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=(AF_THRESH==0).
REQ-029 Reset mid-operation SHALL discard all queued data; memory contents need no reset.

Structure
REQ-030 SHALL take the FWFT mode constants (FWFT_OFF=0, FWFT_ON=1) and the pointer/count width helpers from shared package sync_fifo_pkg.
REQ-031 SHALL place storage in one sub-module fifo_ram (simple dual-port, synchronous write, asynchronous read, WIDTH x DEPTH).
REQ-032 SHALL check at elaboration that AE_THRESH < AF_THRESH <= DEPTH and DEPTH >= 2.

Verification (WIDTH=8, DEPTH=6, AF=4, AE=1)
REQ-033 Write 0x11..0x16 -> fifo_full=1 and count=6; a 7th write sets overflow=1, and the FIFO contents are unchanged.
REQ-034 Read 6 words, FWFT=0 -> data_out shows 0x11..0x16 one cycle after each read edge; a 7th read sets underflow=1 and data_out holds 0x16.
REQ-035 Run 20 cycles of simultaneous w/r at count=3 -> count stays 3, pointers wrap past 5, and the output order matches input order.
REQ-036 At full, apply w_in and r_in together -> write accepted, count stays 6, overflow stays 0.
REQ-037 FWFT=1: write 0xA5 into an empty FIFO -> data_out=0xA5 next cycle without r_in, and r_in clears it to empty.
REQ-038 At count=4 with overflow set, pulse flush, then pulse rst low asynchronously mid-write -> count=0, flags cleared, and all outputs reach their reset values without a clock edge.
